// File: rtl/gpio_msg_scheduler.sv
// Shares the LCD between keystroke echo and received-message display, and assembles
// keystrokes into outgoing GPIO messages. Optional send timeout: GPIO_MSG_SCHED_LINK_TIMEOUT_EN.
module gpio_msg_scheduler #(
    parameter int unsigned MSG_BYTES      = 16,
    parameter logic [7:0]  ENTER_CODE     = 8'h0D,
    parameter logic [7:0]  BS_CODE        = 8'h08,
    parameter logic [7:0]  PAD_CHAR       = 8'h20,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   key_valid,
    input  logic [7:0]             key_ascii,
    output logic [8*MSG_BYTES-1:0] msg_out,
    output logic                   data_ready,
    input  logic                   link_done,
    input  logic                   rx_valid,
    input  logic [8*MSG_BYTES-1:0] rx_msg,
    output logic                   lcd_valid,
    output logic [7:0]             lcd_char,
    input  logic                   lcd_busy,
    output logic [4:0]             char_count,
    output logic                   key_drop,
    output logic                   rx_drop,
    output logic [1:0]             fsm_state
);
    localparam int unsigned MSG_W = 8 * MSG_BYTES;
    localparam int unsigned POS_W = $clog2(MSG_W);
    localparam int unsigned IDX_W = $clog2(MSG_BYTES);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DRAIN = 2'd2} state_t;

    state_t             state, state_d;
    logic [MSG_W-1:0]   msg_d, rx_buf, rx_buf_d;
    logic [4:0]         count_d;
    logic               ready_d, lcd_valid_d, key_drop_d, rx_drop_d;
    logic [7:0]         lcd_char_d;
    logic               rx_pend, rx_pend_d;
    logic [IDX_W-1:0]   drain_idx, drain_idx_d;
    logic               ld_meta, ld_sync, ld_prev, link_edge;
    logic               lcd_done, go_send, send_end, is_print;
    logic [POS_W-1:0]   wr_pos, bs_pos, rd_pos;

`ifdef GPIO_MSG_SCHED_LINK_TIMEOUT_EN
    logic [31:0]        to_cnt, to_cnt_d;
`else
    logic               timeout_unused;
    assign timeout_unused = ^TIMEOUT_CYCLES;
`endif

    assign fsm_state = state;
    assign link_edge = ld_sync & ~ld_prev;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        msg_d       = msg_out;
        count_d     = char_count;
        ready_d     = data_ready;
        lcd_valid_d = lcd_valid;
        lcd_char_d  = lcd_char;
        key_drop_d  = 1'b0;
        rx_drop_d   = 1'b0;
        rx_buf_d    = rx_buf;
        rx_pend_d   = rx_pend;
        drain_idx_d = drain_idx;
        go_send     = 1'b0;
        send_end    = 1'b0;
`ifdef GPIO_MSG_SCHED_LINK_TIMEOUT_EN
        to_cnt_d    = to_cnt;
`endif
        lcd_done = lcd_valid & ~lcd_busy;
        is_print = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
        wr_pos   = POS_W'(MSG_W - 8 - 8 * int'(char_count));
        bs_pos   = POS_W'(MSG_W - 8 * int'(char_count));
        rd_pos   = POS_W'(MSG_W - 8 - 8 * int'(drain_idx));

        if (lcd_done) lcd_valid_d = 1'b0;

        // Keys are only accepted in IDLE with no echo outstanding
        if (key_valid && (state != IDLE || lcd_valid)) key_drop_d = 1'b1;

        // Single-entry receive buffer outside DRAIN
        if (rx_valid) begin
            if (state == DRAIN || rx_pend) begin
                rx_drop_d = 1'b1;
            end else begin
                rx_buf_d  = rx_msg;
                rx_pend_d = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (key_valid && !lcd_valid) begin
                    if (key_ascii == ENTER_CODE) begin
                        go_send = (char_count != 5'd0);
                    end else if (key_ascii == BS_CODE) begin
                        if (char_count != 5'd0) begin
                            msg_d[bs_pos +: 8] = PAD_CHAR;
                            count_d            = char_count - 5'd1;
                            lcd_valid_d        = 1'b1;
                            lcd_char_d         = BS_CODE;
                        end
                    end else if (is_print) begin
                        msg_d[wr_pos +: 8] = key_ascii;
                        count_d            = char_count + 5'd1;
                        lcd_valid_d        = 1'b1;
                        lcd_char_d         = key_ascii;
                        go_send            = (char_count == 5'(MSG_BYTES - 1));
                    end
                end
                if (go_send) begin
                    state_d = SEND;
                    ready_d = 1'b1;
`ifdef GPIO_MSG_SCHED_LINK_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else if (rx_pend_d && !lcd_valid_d) begin
                    state_d     = DRAIN;
                    drain_idx_d = '0;
                end
            end
            SEND: begin
                if (link_edge) begin
                    send_end = 1'b1;
                    msg_d    = {MSG_BYTES{PAD_CHAR}};
                    count_d  = 5'd0;
                end
`ifdef GPIO_MSG_SCHED_LINK_TIMEOUT_EN
                to_cnt_d = to_cnt + 32'd1;
                // Abort keeps the buffer so Enter can resend it
                if (!link_edge && to_cnt == TIMEOUT_CYCLES - 32'd1) send_end = 1'b1;
`endif
                if (send_end) begin
                    ready_d     = 1'b0;
                    drain_idx_d = '0;
                    state_d     = (rx_pend_d && !lcd_valid_d) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (!lcd_valid) begin
                    lcd_valid_d = 1'b1;
                    lcd_char_d  = rx_buf[rd_pos +: 8];
                end else if (lcd_done) begin
                    if (drain_idx == IDX_W'(MSG_BYTES - 1)) begin
                        state_d     = IDLE;
                        rx_pend_d   = 1'b0;
                        drain_idx_d = '0;
                    end else begin
                        drain_idx_d = drain_idx + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; link_done synchronizer
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            msg_out    <= {MSG_BYTES{PAD_CHAR}};
            char_count <= 5'd0;
            data_ready <= 1'b0;
            lcd_valid  <= 1'b0;
            lcd_char   <= 8'h00;
            key_drop   <= 1'b0;
            rx_drop    <= 1'b0;
            rx_buf     <= {MSG_BYTES{PAD_CHAR}};
            rx_pend    <= 1'b0;
            drain_idx  <= '0;
            ld_meta    <= 1'b0;
            ld_sync    <= 1'b0;
            ld_prev    <= 1'b0;
`ifdef GPIO_MSG_SCHED_LINK_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            state      <= state_d;
            msg_out    <= msg_d;
            char_count <= count_d;
            data_ready <= ready_d;
            lcd_valid  <= lcd_valid_d;
            lcd_char   <= lcd_char_d;
            key_drop   <= key_drop_d;
            rx_drop    <= rx_drop_d;
            rx_buf     <= rx_buf_d;
            rx_pend    <= rx_pend_d;
            drain_idx  <= drain_idx_d;
            ld_meta    <= link_done;
            ld_sync    <= ld_meta;
            ld_prev    <= ld_sync;
`ifdef GPIO_MSG_SCHED_LINK_TIMEOUT_EN
            to_cnt     <= to_cnt_d;
`endif
        end
    end
endmodule
